gates_arbiter: RTL and testbench

- Shares one AND/OR gate unit between NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Registered result with a per-requester ack pulse.
- Sits between several client blocks and a single shared gates datapath; serves as a TMR-triplication test vehicle for FSM, counter and pointer logic.

---
 rtl/gates_arbiter.sv | 179 +++++++++++++++++
 tb/tb_gates_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gates_arbiter.sv
// Purpose : round-robin arbiter sharing one AND/OR gate unit among NREQ requesters.
// Latency : grant one cycle after req is sampled in IDLE; valid/ack two cycles after. At most one operation every 3 cycles.
// Backpres: requesters hold req (level) until their ack; req arriving outside IDLE waits for IDLE.
//
// Ports:
//   clk, rstn        clock (rising edge) and async active-low reset
//   req[NREQ]        per-requester request level
//   in1/in2          packed operands, requester i at [i*WIDTH +: WIDTH]
//   grant[NREQ]      one-hot winner of the operation in flight, 0 when idle
//   ack[NREQ]        one-hot 1-cycle pulse to the winner when the result is valid
//   valid            result valid pulse, coincident with ack
//   out1/out2        registered A&B / A|B of the winner, held until the next operation
//   out_id           winner index, qualified by valid
//   busy             high whenever the FSM is not IDLE
//   fsm_err          (GATES_ARB_FSM_RECOVER_EN only) pulse after an illegal state is seen
//
// Optional feature macro: GATES_ARB_FSM_RECOVER_EN selects a one-hot state encoding
// with illegal-state recovery and the fsm_err output. Without it the state is binary.
module gates_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
`ifdef GATES_ARB_FSM_RECOVER_EN
    output logic                      fsm_err,
`endif
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     in1,
    input  logic [NREQ*WIDTH-1:0]     in2,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           ack,
    output logic                      valid,
    output logic [WIDTH-1:0]          out1,
    output logic [WIDTH-1:0]          out2,
    output logic [$clog2(NREQ)-1:0]   out_id,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW:0]     NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0]   LAST   = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0]  ONE    = NREQ'(1);

`ifdef GATES_ARB_FSM_RECOVER_EN
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        EXEC = 3'b010,
        RESP = 3'b100
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   win_q, win_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic [IDW-1:0]   out_id_q, out_id_d;

    // Round-robin search result
    logic             found;
    logic [IDW-1:0]   pick;
    logic [IDW:0]     cand;
    logic [NREQ-1:0]  win_oh;

    // First asserted request at or above ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDW-1:0];
            end
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        out1_d   = out1_q;
        out2_d   = out2_q;
        out_id_d = out_id_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = EXEC;
                    win_d   = pick;
                    // Latch the winner's operands so the requester may change them after grant.
                    opa_d   = in1[int'(pick)*WIDTH +: WIDTH];
                    opb_d   = in2[int'(pick)*WIDTH +: WIDTH];
                end
            end
            EXEC: begin
                state_d  = RESP;
                out1_d   = opa_q & opb_q;
                out2_d   = opa_q | opb_q;
                out_id_d = win_q;
            end
            RESP: begin
                state_d = IDLE;
                // Advance past the winner so a still-held request cannot starve others.
                ptr_d   = (win_q == LAST) ? '0 : win_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            out1_q   <= '0;
            out2_q   <= '0;
            out_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            out1_q   <= out1_d;
            out2_q   <= out2_d;
            out_id_q <= out_id_d;
        end
    end

`ifdef GATES_ARB_FSM_RECOVER_EN
    logic legal;
    logic fsm_err_q;

    assign legal = (state_q == IDLE) || (state_q == EXEC) || (state_q == RESP);

    // One-cycle pulse on the edge that pulls an illegal state back to IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_err_q <= 1'b0;
        end else begin
            fsm_err_q <= !legal;
        end
    end

    assign fsm_err = fsm_err_q;
`endif

    // grant/ack/valid decode only legal EXEC/RESP codes, so they stay 0 in any
    // illegal state and drop immediately on async reset.
    assign win_oh = ONE << win_q;
    assign busy   = (state_q != IDLE);
    assign valid  = (state_q == RESP);
    assign grant  = ((state_q == EXEC) || (state_q == RESP)) ? win_oh : '0;
    assign ack    = (state_q == RESP) ? win_oh : '0;
    assign out1   = out1_q;
    assign out2   = out2_q;
    assign out_id = out_id_q;

endmodule

// File: tb/tb_gates_arbiter.sv
// Purpose : directed, table-driven self-checking bench for gates_arbiter (NREQ=4, WIDTH=8).
// Latency : expects grant one cycle and valid/ack two cycles after req is sampled in IDLE.
// Backpres: requesters hold req until ack, except the abort vectors which drop it after grant.
module tb_gates_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic [31:0] in1, in2;
    logic [3:0]  grant, ack;
    logic        valid;
    logic [7:0]  out1, out2;
    logic [1:0]  out_id;
    logic        busy;

    int errors = 0;
    int checks = 0;

    gates_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .req    (req),
        .in1    (in1),
        .in2    (in2),
        .grant  (grant),
        .ack    (ack),
        .valid  (valid),
        .out1   (out1),
        .out2   (out2),
        .out_id (out_id),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        req  = '0;
        tick;
        rstn = 1'b1;
        tick;
    endtask

    // One full operation: IDLE sample -> EXEC -> RESP -> IDLE.
    task automatic run_op(input logic [3:0] r, input logic [7:0] a, input logic [7:0] b,
                          input int id, input logic [7:0] e1, input logic [7:0] e2,
                          input bit abort, input string tag);
        for (int j = 0; j < 4; j++) begin
            in1[j*8 +: 8] = (j == id) ? a : 8'(j) + 8'h5A;
            in2[j*8 +: 8] = (j == id) ? b : 8'(j) + 8'hA4;
        end
        req = r;
        tick;
        check({tag, ".grant"}, 32'(grant), 32'(1) << id);
        check({tag, ".busy"},  32'(busy),  32'(1));
        check({tag, ".valid_exec"}, 32'(valid), 32'(0));
        in1 = ~in1;
        in2 = ~in2;
        if (abort) req = '0;
        tick;
        check({tag, ".valid"},  32'(valid),  32'(1));
        check({tag, ".ack"},    32'(ack),    32'(1) << id);
        check({tag, ".grant_resp"}, 32'(grant), 32'(1) << id);
        check({tag, ".out1"},   32'(out1),   32'(e1));
        check({tag, ".out2"},   32'(out2),   32'(e2));
        check({tag, ".out_id"}, 32'(out_id), 32'(id));
        req = '0;
        tick;
        check({tag, ".busy_idle"},  32'(busy),  32'(0));
        check({tag, ".grant_idle"}, 32'(grant), 32'(0));
        check({tag, ".ack_idle"},   32'(ack),   32'(0));
        check({tag, ".out1_hold"},  32'(out1),  32'(e1));
    endtask

    typedef struct {
        logic [3:0] req;
        logic [7:0] a;
        logic [7:0] b;
        int         id;
        logic [7:0] e1;
        logic [7:0] e2;
        bit         abort;
    } vec_t;

    vec_t vt[8];

    initial begin
        // Vectors run back to back from reset, so the winner column tracks the pointer.
        vt[0] = '{4'b0001, 8'hF0, 8'h3C, 0, 8'h30, 8'hFC, 1'b0};
        vt[1] = '{4'b1000, 8'hAA, 8'h0F, 3, 8'h0A, 8'hAF, 1'b0};
        vt[2] = '{4'b1001, 8'hFF, 8'h81, 0, 8'h81, 8'hFF, 1'b0};
        vt[3] = '{4'b1001, 8'h12, 8'h34, 3, 8'h10, 8'h36, 1'b0};
        vt[4] = '{4'b0110, 8'hC3, 8'h5A, 1, 8'h42, 8'hDB, 1'b1};
        vt[5] = '{4'b0110, 8'h00, 8'h00, 2, 8'h00, 8'h00, 1'b0};
        vt[6] = '{4'b0011, 8'h55, 8'hAA, 0, 8'h00, 8'hFF, 1'b1};
        vt[7] = '{4'b1111, 8'h0F, 8'hF0, 1, 8'h00, 8'hFF, 1'b0};

        rstn = 1'b0;
        req  = '0;
        in1  = '0;
        in2  = '0;
        #12;
        check("rst.grant",  32'(grant),  32'(0));
        check("rst.ack",    32'(ack),    32'(0));
        check("rst.valid",  32'(valid),  32'(0));
        check("rst.out1",   32'(out1),   32'(0));
        check("rst.out2",   32'(out2),   32'(0));
        check("rst.out_id", 32'(out_id), 32'(0));
        check("rst.busy",   32'(busy),   32'(0));
        rstn = 1'b1;
        tick;
        tick;
        check("idle.busy",  32'(busy),  32'(0));
        check("idle.grant", 32'(grant), 32'(0));

        for (int k = 0; k < 8; k++) begin
            run_op(vt[k].req, vt[k].a, vt[k].b, vt[k].id, vt[k].e1, vt[k].e2,
                   vt[k].abort, $sformatf("vec%0d", k));
        end

        // Round-robin with all requesters held; each drops for one cycle after its ack.
        do_reset;
        begin
            logic [3:0] restore;
            int         n;
            restore = '0;
            n       = 0;
            req     = 4'b1111;
            for (int c = 0; c < 80 && n < 6; c++) begin
                tick;
                req     = req | restore;
                restore = '0;
                if (ack != 4'b0000) begin
                    check($sformatf("rr.ack%0d", n), 32'(ack), 32'(1) << (n % 4));
                    req     = req & ~ack;
                    restore = ack;
                    n++;
                end
            end
            check("rr.count", 32'(n), 32'(6));
            req = '0;
            tick;
            tick;
        end

        // Late request: req[2] rises while requester 1 is in flight.
        do_reset;
        req = 4'b0010;
        tick;
        check("late.grant_exec", 32'(grant), 32'h2);
        req = 4'b0110;
        tick;
        check("late.grant_resp", 32'(grant), 32'h2);
        check("late.ack1",       32'(ack),   32'h2);
        req = 4'b0100;
        tick;
        check("late.grant_idle", 32'(grant), 32'h0);
        tick;
        check("late.grant2",     32'(grant), 32'h4);
        tick;
        check("late.ack2",       32'(ack),   32'h4);
        req = '0;
        tick;

        // Reset during EXEC, then a fresh operation from requester 2.
        do_reset;
        in1 = 32'h000000F0;
        in2 = 32'h0000003C;
        req = 4'b0001;
        tick;
        check("rmid.grant_exec", 32'(grant), 32'h1);
        rstn = 1'b0;
        #1;
        check("rmid.grant", 32'(grant), 32'h0);
        check("rmid.ack",   32'(ack),   32'h0);
        check("rmid.valid", 32'(valid), 32'h0);
        check("rmid.busy",  32'(busy),  32'h0);
        req = '0;
        tick;
        rstn = 1'b1;
        tick;
        run_op(4'b0100, 8'h3C, 8'hC3, 2, 8'h00, 8'hFF, 1'b0, "rmid.op");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
